// File: rtl/mips_fmt_pkg.sv
// Shared MIPS encoding definitions: format codes, field widths, text segment base
// and the assembler's session states.
package mips_fmt_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_BAD = 2'b11
  } fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_FULL
  } asm_state_e;

  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNC_W  = 6;
  localparam int IMM_W   = 16;
  localparam int INDEX_W = 26;

endpackage

// File: rtl/instr_assembler_if.sv
// Field-tuple handshake into the assembler plus the instruction-memory write bus out of it.
interface instr_assembler_if;
  import mips_fmt_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [1:0]         fmt;
  logic [OP_W-1:0]    op;
  logic [REG_W-1:0]   rs;
  logic [REG_W-1:0]   rt;
  logic [REG_W-1:0]   rd;
  logic [SHAMT_W-1:0] shamt;
  logic [FUNC_W-1:0]  func;
  logic [IMM_W-1:0]   immediate;
  logic [INDEX_W-1:0] instr_index;
  logic               last;

  logic               im_we;
  logic [31:0]        im_addr;
  logic [31:0]        im_wdata;

  modport master (
    output in_valid, fmt, op, rs, rt, rd, shamt, func, immediate, instr_index, last,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, fmt, op, rs, rt, rd, shamt, func, immediate, instr_index, last,
    output in_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/instr_field_packer.sv
// Combinational R/I/J packer; the illegal format yields a nop and raises bad.
module instr_field_packer
  import mips_fmt_pkg::*;
(
  input  fmt_e               fmt,
  input  logic [OP_W-1:0]    op,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [FUNC_W-1:0]  func,
  input  logic [IMM_W-1:0]   immediate,
  input  logic [INDEX_W-1:0] instr_index,
  output logic [31:0]        word,
  output logic               bad
);

  always_comb begin
    word = NOP_WORD;
    bad  = 1'b0;
    case (fmt)
      FMT_R:   word = {op, rs, rt, rd, shamt, func};
      FMT_I:   word = {op, rs, rt, immediate};
      FMT_J:   word = {op, instr_index};
      default: bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Packs decoded field tuples into instruction words and streams them into IM
// at consecutive word addresses, under a start/last/done session protocol.
module instr_assembler
  import mips_fmt_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = TEXT_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_assembler_if.slave      bus,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  bad_fmt
);

  localparam logic [DEPTH_LOG2:0] CAPACITY  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LAST_SLOT = {1'b0, {DEPTH_LOG2{1'b1}}};
  localparam logic [DEPTH_LOG2:0] COUNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  asm_state_e  state, state_next;
  logic        can_accept;
  logic        xfer;
  logic        session_clear;
  logic [31:0] packed_word;
  logic        packed_bad;

  assign can_accept   = (state == ST_RUN) && (word_count < CAPACITY);
  assign bus.in_ready = can_accept;
  assign xfer         = bus.in_valid && can_accept;

  instr_field_packer u_packer (
    .fmt         (fmt_e'(bus.fmt)),
    .op          (bus.op),
    .rs          (bus.rs),
    .rt          (bus.rt),
    .rd          (bus.rd),
    .shamt       (bus.shamt),
    .func        (bus.func),
    .immediate   (bus.immediate),
    .instr_index (bus.instr_index),
    .word        (packed_word),
    .bad         (packed_bad)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A last on the capacity-filling word wins over FULL, so an exact fit ends cleanly.
  always_comb begin
    state_next    = state;
    session_clear = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    overflow      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_RUN;
          session_clear = 1'b1;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (xfer) begin
          if (bus.last)                     state_next = ST_DRAIN;
          else if (word_count == LAST_SLOT) state_next = ST_FULL;
        end
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_next    = ST_RUN;
          session_clear = 1'b1;
        end
      end
      ST_FULL: begin
        overflow = 1'b1;
        if (start) begin
          state_next    = ST_RUN;
          session_clear = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.im_we    <= 1'b0;
      bus.im_addr  <= BASE_ADDR;
      bus.im_wdata <= NOP_WORD;
      word_count   <= '0;
      bad_fmt      <= 1'b0;
    end else begin
      bus.im_we <= xfer;
      if (session_clear) begin
        word_count <= '0;
        bad_fmt    <= 1'b0;
      end else if (xfer) begin
        bus.im_addr  <= BASE_ADDR + {{(29-DEPTH_LOG2){1'b0}}, word_count, 2'b00};
        bus.im_wdata <= packed_word;
        word_count   <= word_count + COUNT_ONE;
        bad_fmt      <= bad_fmt | packed_bad;
      end
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler with a small IM capacity so FULL is reachable;
// expected IM writes are queued when a tuple is driven and popped when im_we fires.
module tb_instr_assembler;
  import mips_fmt_pkg::*;

  localparam int DEPTH_LOG2 = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [DEPTH_LOG2:0] word_count;
  logic                busy;
  logic                done;
  logic                overflow;
  logic                bad_fmt;

  instr_assembler_if bus ();

  instr_assembler #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BASE_ADDR  (32'h0000_3000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .bad_fmt    (bad_fmt)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic        exp_we   = 1'b0;
  int          exp_idx  = 0;
  logic [63:0] sb[$];

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and compare the write port against the scoreboard head.
  task automatic step();
    logic [63:0] e;
    @(posedge clk);
    #1;
    check_output("im_we", 32'(bus.im_we), 32'(exp_we));
    if (exp_we) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard observed=empty expected=entry");
      end else begin
        e = sb.pop_front();
        check_output("im_addr", bus.im_addr, e[63:32]);
        check_output("im_wdata", bus.im_wdata, e[31:0]);
      end
    end
    exp_we = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                                input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] idx,
                                input logic lst, input logic accept, input logic [31:0] exp_word);
    bus.fmt         = f;
    bus.op          = op;
    bus.rs          = rs;
    bus.rt          = rt;
    bus.rd          = rd;
    bus.shamt       = sh;
    bus.func        = fn;
    bus.immediate   = imm;
    bus.instr_index = idx;
    bus.last        = lst;
    bus.in_valid    = 1'b1;
    check_output("in_ready", 32'(bus.in_ready), 32'(accept));
    if (accept) begin
      sb.push_back({32'h0000_3000 + 32'(exp_idx) * 32'd4, exp_word});
      exp_idx++;
      exp_we = 1'b1;
    end
    step();
    bus.in_valid = 1'b0;
    bus.last     = 1'b0;
  endtask

  task automatic send_j(input logic [25:0] idx, input logic lst, input logic accept, input logic [31:0] exp_word);
    apply_stimulus(FMT_J, 6'h02, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, idx, lst, accept, exp_word);
  endtask

  task automatic pulse_start(input logic new_session);
    start = 1'b1;
    if (new_session) exp_idx = 0;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.fmt = 2'b00; bus.op = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
    bus.shamt = '0; bus.func = '0; bus.immediate = '0; bus.instr_index = '0; bus.last = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_im_addr", bus.im_addr, 32'h0000_3000);
    check_output("rst_im_wdata", bus.im_wdata, 32'h0);
    check_output("rst_word_count", 32'(word_count), 32'd0);
    check_output("rst_flags", {28'd0, busy, done, overflow, bad_fmt}, 32'h0);

    // Single R-format word closing the session.
    pulse_start(1'b1);
    apply_stimulus(FMT_R, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0022_1821);
    check_output("drain_busy", 32'(busy), 32'd1);
    check_output("drain_done", 32'(done), 32'd0);
    step();
    check_output("t1_done", 32'(done), 32'd1);
    check_output("t1_busy", 32'(busy), 32'd0);
    check_output("t1_count", 32'(word_count), 32'd1);

    // Back-to-back I then J.
    pulse_start(1'b1);
    check_output("t2_count_clr", 32'(word_count), 32'd0);
    apply_stimulus(FMT_I, 6'h0d, 5'd0, 5'd1, 5'd7, 5'd9, 6'h2a, 16'h1234, 26'h0, 1'b0, 1'b1, 32'h3401_1234);
    send_j(26'h000_0C00, 1'b1, 1'b1, 32'h0800_0C00);
    step();
    check_output("t2_done", 32'(done), 32'd1);
    check_output("t2_count", 32'(word_count), 32'd2);
    check_output("t2_bad_fmt", 32'(bad_fmt), 32'd0);

    // Illegal format mid-stream with a gap in in_valid.
    pulse_start(1'b1);
    apply_stimulus(FMT_R, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0085_3021);
    step();
    apply_stimulus(FMT_BAD, 6'h3f, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 6'h3f, 16'hffff, 26'h3ff_ffff, 1'b0, 1'b1, 32'h0);
    check_output("t3_bad_set", 32'(bad_fmt), 32'd1);
    send_j(26'h000_0010, 1'b1, 1'b1, 32'h0800_0010);
    step();
    check_output("t3_done", 32'(done), 32'd1);
    check_output("t3_bad_held", 32'(bad_fmt), 32'd1);
    check_output("t3_count", 32'(word_count), 32'd3);
    pulse_start(1'b1);
    check_output("t3_bad_clr", 32'(bad_fmt), 32'd0);
    check_output("t3_count_clr", 32'(word_count), 32'd0);

    // start while running is ignored, then reset right after a transfer.
    send_j(26'h000_0001, 1'b0, 1'b1, 32'h0800_0001);
    pulse_start(1'b0);
    check_output("run_start_count", 32'(word_count), 32'd1);
    check_output("run_start_busy", 32'(busy), 32'd1);
    send_j(26'h000_0002, 1'b0, 1'b1, 32'h0800_0002);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("mid_rst_count", 32'(word_count), 32'd0);
    check_output("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("mid_rst_im_addr", bus.im_addr, 32'h0000_3000);
    check_output("mid_rst_im_wdata", bus.im_wdata, 32'h0);
    check_output("mid_rst_flags", {28'd0, busy, done, overflow, bad_fmt}, 32'h0);

    // Overflow: four words fill the IM, the fifth is refused.
    pulse_start(1'b1);
    for (int i = 1; i <= 4; i++)
      send_j(26'(32'h10 + i), 1'b0, 1'b1, 32'h0800_0010 + 32'(i));
    check_output("full_overflow", 32'(overflow), 32'd1);
    check_output("full_busy", 32'(busy), 32'd0);
    check_output("full_count", 32'(word_count), 32'd4);
    send_j(26'h000_0015, 1'b0, 1'b0, 32'h0);
    check_output("full_count_held", 32'(word_count), 32'd4);
    check_output("full_overflow_held", 32'(overflow), 32'd1);

    // Exact fit: last on the capacity-filling word.
    pulse_start(1'b1);
    check_output("fit_overflow_clr", 32'(overflow), 32'd0);
    for (int i = 1; i <= 4; i++)
      send_j(26'(32'h20 + i), (i == 4), 1'b1, 32'h0800_0020 + 32'(i));
    check_output("fit_busy", 32'(busy), 32'd1);
    check_output("fit_overflow", 32'(overflow), 32'd0);
    step();
    check_output("fit_done", 32'(done), 32'd1);
    check_output("fit_no_overflow", 32'(overflow), 32'd0);
    check_output("fit_count", 32'(word_count), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
